// File: rtl/bp_fifo_rolly_replay_ctrl_if.sv
// Handshake bundle between the replay sequencer, the rollback FIFO read side and the consumer.
// master = sequencer, slave = FIFO/consumer side.
interface bp_fifo_rolly_replay_ctrl_if #(
    parameter int els_p = 8
);
    localparam int cnt_w = $clog2(els_p + 1);

    logic             fifo_v;
    logic             fifo_yumi;
    logic             fifo_deq_v;
    logic             fifo_roll_v;
    logic             fifo_clr_v;
    logic             issue_v;
    logic             issue_ready;
    logic             commit_v;
    logic             flush_v;
    logic             clear_v;
    logic [cnt_w-1:0] inflight;
    logic [15:0]      roll_count;
    logic             err;

    modport master (
        input  fifo_v, issue_ready, commit_v, flush_v, clear_v,
        output fifo_yumi, fifo_deq_v, fifo_roll_v, fifo_clr_v, issue_v,
        output inflight, roll_count, err
    );

    modport slave (
        output fifo_v, issue_ready, commit_v, flush_v, clear_v,
        input  fifo_yumi, fifo_deq_v, fifo_roll_v, fifo_clr_v, issue_v,
        input  inflight, roll_count, err
    );
endinterface

// File: rtl/bp_fifo_rolly_replay_ctrl.sv
// Speculative issue sequencer for a rollback FIFO: tracks issued-but-uncommitted entries and
// turns commit/flush/clear into deq/roll/clr strobes, with a replay bubble after each roll.
module bp_fifo_rolly_replay_ctrl #(
    parameter int els_p          = 8,
    parameter int max_inflight_p = 8,
    parameter int replay_delay_p = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_fifo_rolly_replay_ctrl_if.master   bus
);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [cnt_w-1:0] max_c   = cnt_w'(max_inflight_p);
    localparam logic [3:0]       delay_c = 4'(replay_delay_p);

    typedef enum logic [0:0] {RUN, ROLL_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [cnt_w-1:0] inflight_reg, inflight_next;
    logic [15:0]      roll_count_reg, roll_count_next;
    logic             err_reg, err_next;

    logic issue, yumi, deq;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg      <= RUN;
            cnt_reg        <= '0;
            inflight_reg   <= '0;
            roll_count_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            inflight_reg   <= inflight_next;
            roll_count_reg <= roll_count_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        inflight_next   = inflight_reg;
        roll_count_next = roll_count_reg;
        err_next        = err_reg;

        issue = (state_reg == RUN) && bus.fifo_v && (inflight_reg < max_c)
                && !bus.flush_v && !bus.clear_v;
        yumi  = issue && bus.issue_ready;
        deq   = bus.commit_v && (inflight_reg != '0);

        if (bus.commit_v && (inflight_reg == '0))
            err_next = 1'b1;

        // The FIFO retires a same-cycle deq before rewinding, so a flush always lands at zero.
        if (bus.flush_v)
            inflight_next = '0;
        else
            inflight_next = inflight_reg + cnt_w'(yumi) - cnt_w'(deq);

        if (bus.flush_v && (roll_count_reg != 16'hFFFF))
            roll_count_next = roll_count_reg + 16'd1;

        case (state_reg)
            RUN: begin
                if (bus.flush_v && (replay_delay_p > 0)) begin
                    state_next = ROLL_WAIT;
                    cnt_next   = delay_c;
                end
            end
            ROLL_WAIT: begin
                if (bus.flush_v) begin
                    cnt_next = delay_c;
                end else if (cnt_reg <= 4'd1) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Combinational strobes are forced low while reset is held.
    assign bus.issue_v     = issue && reset_n_i;
    assign bus.fifo_yumi   = yumi && reset_n_i;
    assign bus.fifo_deq_v  = deq && reset_n_i;
    assign bus.fifo_roll_v = bus.flush_v && reset_n_i;
    assign bus.fifo_clr_v  = bus.clear_v && reset_n_i;
    assign bus.inflight    = inflight_reg;
    assign bus.roll_count  = roll_count_reg;
    assign bus.err         = err_reg;
endmodule

// File: tb/tb_bp_fifo_rolly_replay_ctrl.sv
// Bench for the rollback-FIFO replay sequencer: directed vector table, reset corner case,
// then random traffic against a cycle-count based reference model.
module tb_bp_fifo_rolly_replay_ctrl;
    localparam int ELS   = 8;
    localparam int MAXF  = 8;
    localparam int DELAY = 2;

    logic clk;
    logic reset_n;

    bp_fifo_rolly_replay_ctrl_if #(.els_p(ELS)) bus ();

    bp_fifo_rolly_replay_ctrl #(
        .els_p(ELS), .max_inflight_p(MAXF), .replay_delay_p(DELAY)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic fv, rdy, cm, fl, cl;
        logic e_issue, e_yumi, e_deq, e_roll, e_clr;
        logic [7:0]  e_inf;
        logic [15:0] e_rc;
        logic e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fv, logic rdy, logic cm, logic fl, logic cl,
                                logic ei, logic ey, logic ed, logic er, logic ec,
                                int inf, int rc, logic ee);
        vec_t v;
        v = '{fv, rdy, cm, fl, cl, ei, ey, ed, er, ec, 8'(inf), 16'(rc), ee};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic rdy, input logic cm,
                         input logic fl, input logic cl);
        bus.fifo_v      = fv;
        bus.issue_ready = rdy;
        bus.commit_v    = cm;
        bus.flush_v     = fl;
        bus.clear_v     = cl;
    endtask

    task automatic chk_all(input string tag, input logic ei, input logic ey, input logic ed,
                           input logic er, input logic ec, input int inf, input int rc,
                           input logic ee);
        chk({tag, ".issue"}, 32'(bus.issue_v), 32'(ei));
        chk({tag, ".yumi"},  32'(bus.fifo_yumi), 32'(ey));
        chk({tag, ".deq"},   32'(bus.fifo_deq_v), 32'(ed));
        chk({tag, ".roll"},  32'(bus.fifo_roll_v), 32'(er));
        chk({tag, ".clr"},   32'(bus.fifo_clr_v), 32'(ec));
        chk({tag, ".inflight"}, 32'(bus.inflight), 32'(inf));
        chk({tag, ".roll_count"}, 32'(bus.roll_count), 32'(rc));
        chk({tag, ".err"},   32'(bus.err), 32'(ee));
    endtask

    // Reference model: issue is blocked until an absolute cycle number after each flush.
    int  m_inflight, m_block_until, m_cycle, m_rc;
    bit  m_err;

    task automatic model_reset();
        m_inflight = 0; m_block_until = 0; m_cycle = 0; m_rc = 0; m_err = 0;
    endtask

    task automatic model_step(input bit fv, input bit rdy, input bit cm, input bit fl, input bit cl);
        bit ei, ey, ed;
        drive(fv, rdy, cm, fl, cl);
        #3;
        ei = fv && (m_inflight < MAXF) && !fl && !cl && (m_cycle >= m_block_until);
        ey = ei && rdy;
        ed = cm && (m_inflight != 0);
        chk_all("rand", ei, ey, ed, fl, cl, m_inflight, m_rc, m_err);
        if (cm && m_inflight == 0) m_err = 1;
        if (fl) begin
            m_inflight    = 0;
            m_block_until = m_cycle + DELAY + 1;
            if (m_rc < 65535) m_rc++;
        end else begin
            m_inflight = m_inflight + int'(ey) - int'(ed);
        end
        m_cycle++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #3;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1);
        #1;
        chk_all("reset_comb", 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        for (int i = 0; i < 8; i++) tbl.push_back(mk(1,1,0,0,0, 1,1,0,0,0, i,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0, 8,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0, 8,0,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,1,1,0,0, 0,0,1,0,0, 8-k,0,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,1,0,0, 5,0,0));
        tbl.push_back(mk(1,1,1,0,0, 1,1,1,0,0, 4,0,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0,0,0, 4,0,0));
        tbl.push_back(mk(1,1,0,1,0, 0,0,0,1,0, 5,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0,0,0, 1,1,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0,0,0, 2,1,0));
        tbl.push_back(mk(1,1,0,0,1, 0,0,0,0,1, 3,1,0));
        tbl.push_back(mk(0,0,1,1,1, 0,0,1,1,1, 3,1,0));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0, 0,2,1));
        tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,0, 0,2,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,2,1));

        foreach (tbl[i]) begin
            drive(tbl[i].fv, tbl[i].rdy, tbl[i].cm, tbl[i].fl, tbl[i].cl);
            #3;
            chk_all($sformatf("vec%0d", i), tbl[i].e_issue, tbl[i].e_yumi, tbl[i].e_deq,
                    tbl[i].e_roll, tbl[i].e_clr, int'(tbl[i].e_inf), int'(tbl[i].e_rc),
                    tbl[i].e_err);
            @(posedge clk); #1;
        end

        // Async reset in the middle of a replay bubble.
        drive(1, 1, 0, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        drive(0, 0, 0, 1, 0);
        @(posedge clk); #1;
        drive(1, 1, 1, 1, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_all("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 0);
        reset_n = 1'b1;
        #3;
        chk_all("release", 1, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("release.inflight_after", 32'(bus.inflight), 32'd1);

        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            model_step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                       $urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0,
                       $urandom_range(0, 24) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
